// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM states, line-mux codes
// and the default frame width.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_e;

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity of the parallel byte; even parity when PAR_TYP=0, odd when 1.
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_TYP,
    output logic                  par_bit
);

    assign par_bit = (^P_DATA) ^ PAR_TYP;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: drives the external serializer and the line mux,
// inserting start, optional parity and one or two stop bits around each byte.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  busy,
    output logic                  TX_OUT
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic FIRST_DATA_EN = (DATA_WIDTH > 1);

    txState_e         state_q;
    logic [CNT_W-1:0] bitCnt_q;
    logic             stopCnt_q;
    logic             parEn_q;
    logic             stop2_q;
    logic             parBit_q;
    logic             serEn_q;
    logic [1:0]       muxSel_q;
    logic             busy_q;
    logic             parBit;
    logic             accept;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .P_DATA  (P_DATA),
        .PAR_TYP (PAR_TYP),
        .par_bit (parBit)
    );

    // busy_q is only low in IDLE and the final stop cycle, so this is the accept window
    assign accept = Data_Valid & ~busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            parEn_q   <= 1'b0;
            stop2_q   <= 1'b0;
            parBit_q  <= 1'b0;
            serEn_q   <= 1'b0;
            muxSel_q  <= MUX_STOP;
            busy_q    <= 1'b0;
        end else if (accept) begin
            state_q   <= START;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            parEn_q   <= PAR_EN;
            stop2_q   <= STOP2;
            parBit_q  <= parBit;
            serEn_q   <= 1'b1;
            muxSel_q  <= MUX_START;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    serEn_q  <= 1'b0;
                    muxSel_q <= MUX_STOP;
                    busy_q   <= 1'b0;
                end
                START: begin
                    state_q  <= DATA;
                    serEn_q  <= FIRST_DATA_EN;
                    muxSel_q <= MUX_DATA;
                    busy_q   <= 1'b1;
                end
                DATA: begin
                    if (bitCnt_q == LAST_BIT) begin
                        bitCnt_q  <= '0;
                        stopCnt_q <= 1'b0;
                        serEn_q   <= 1'b0;
                        if (parEn_q) begin
                            state_q  <= PARITY;
                            muxSel_q <= MUX_PARITY;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= STOP;
                            muxSel_q <= MUX_STOP;
                            busy_q   <= stop2_q;
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CNT_W'(1);
                        // the serializer needs no shift on the last data bit
                        serEn_q  <= (int'(bitCnt_q) + 2 < DATA_WIDTH);
                    end
                end
                PARITY: begin
                    state_q   <= STOP;
                    stopCnt_q <= 1'b0;
                    muxSel_q  <= MUX_STOP;
                    busy_q    <= stop2_q;
                end
                STOP: begin
                    if (stop2_q && !stopCnt_q) begin
                        stopCnt_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        stopCnt_q <= 1'b0;
                        muxSel_q  <= MUX_STOP;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serEn_q  <= 1'b0;
                    muxSel_q <= MUX_STOP;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        TX_OUT = 1'b1;
        case (muxSel_q)
            MUX_START:  TX_OUT = 1'b0;
            MUX_STOP:   TX_OUT = 1'b1;
            MUX_DATA:   TX_OUT = ser_data;
            MUX_PARITY: TX_OUT = parBit_q;
            default:    TX_OUT = 1'b1;
        endcase
    end

    assign ser_en  = serEn_q;
    assign mux_sel = muxSel_q;
    assign busy    = busy_q;

endmodule
